telemetry_tx: RTL

TELEMETRY_TX -- requirements
Module: telemetry_tx

---
 rtl/telemetry_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/telemetry_tx.sv
// telemetry_tx: periodic UART telemetry transmitter.
// A free-running period counter triggers an 8-byte packet
// (AA 55 batt_hi batt_lo curr_hi curr_lo torque_hi torque_lo), sent 8N1, LSB first.
// The sensor inputs are snapshotted on the accepted trigger.
// A trigger that arrives while a packet is still in flight is dropped.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   batt_v     battery voltage sample (12 bit)
//   avg_curr   averaged motor current (12 bit)
//   avg_torque averaged pedal torque (12 bit)
//   TX         UART serial output, idle high
//   busy       high while a packet is being shifted out
//   pkt_done   one-cycle pulse in the last cycle of the final stop bit
module telemetry_tx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned PERIOD_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] batt_v,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);

  typedef enum logic {StIdle, StTxing} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [2:0]          byte_q, byte_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [11:0]         batt_q, curr_q, torque_q;
  logic                snap_en;
  logic [7:0]          next_byte;

  logic trigger, bit_end, last_bit, last_byte;

  assign trigger   = &period_q;
  assign bit_end   = (baud_q == BaudLast);
  assign last_bit  = (bit_q == 4'd9);
  assign last_byte = (byte_q == 3'd7);

  // Byte that follows the one currently indexed by byte_q.
  always_comb begin
    next_byte = 8'hFF;
    case (byte_q)
      3'd0:    next_byte = 8'h55;
      3'd1:    next_byte = {4'h0, batt_q[11:8]};
      3'd2:    next_byte = batt_q[7:0];
      3'd3:    next_byte = {4'h0, curr_q[11:8]};
      3'd4:    next_byte = curr_q[7:0];
      3'd5:    next_byte = {4'h0, torque_q[11:8]};
      3'd6:    next_byte = torque_q[7:0];
      default: next_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    snap_en  = 1'b0;
    pkt_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (trigger) begin
          // The first start bit is driven straight from the trigger edge.
          state_d = StTxing;
          snap_en = 1'b1;
          baud_d  = '0;
          bit_d   = 4'd0;
          byte_d  = 3'd0;
          shift_d = 8'hAA;
          tx_d    = 1'b0;
        end
      end
      StTxing: begin
        if (bit_end) begin
          baud_d = '0;
          if (last_bit) begin
            bit_d = 4'd0;
            if (last_byte) begin
              pkt_done = 1'b1;
              state_d  = StIdle;
              byte_d   = 3'd0;
              tx_d     = 1'b1;
            end else begin
              byte_d  = byte_q + 3'd1;
              shift_d = next_byte;
              tx_d    = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d    = shift_q[0];
              shift_d = {1'b0, shift_q[7:1]};
            end
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      period_q <= '0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      byte_q   <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      batt_q   <= 12'h000;
      curr_q   <= 12'h000;
      torque_q <= 12'h000;
    end else begin
      state_q  <= state_d;
      period_q <= period_q + PERIOD_W'(1);
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      if (snap_en) begin
        batt_q   <= batt_v;
        curr_q   <= avg_curr;
        torque_q <= avg_torque;
      end
    end
  end

  assign TX   = tx_q;
  assign busy = (state_q == StTxing);

endmodule
